// File: rtl/mux_arb_pkg.sv
// mux_arb_pkg: shared state type and index helper for the round-robin mux arbiter.
package mux_arb_pkg;
    typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t;
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin search for the first requester at or after ptr, modulo INPS.
module rr_pick #(
    parameter int INPS = 5,
    localparam int SW = $clog2(INPS)
) (
    input  logic [INPS-1:0] req,
    input  logic [SW-1:0]   ptr,
    output logic [SW-1:0]   winner,
    output logic            any
);
    logic [SW-1:0] w_idx [INPS];
    for (genvar k = 0; k < INPS; k++) begin : g_idx
        assign w_idx[k] = SW'((int'(ptr) + k) % INPS);
    end
    // Scan from lowest priority upward so the highest-priority hit is written last.
    always_comb begin
        winner = '0;
        any = |req;
        for (int k = INPS - 1; k >= 0; k--)
            if (req[w_idx[k]]) winner = w_idx[k];
    end
endmodule

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: round-robin arbiter with hold limit steering w[sel] to f while a grant is held.
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int INPS = 5,
    parameter int MAX_HOLD = 4,
    localparam int SW = $clog2(INPS),
    localparam int CW = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [INPS-1:0] req,
    input  logic [INPS-1:0] w,
    output logic [INPS-1:0] gnt,
    output logic [SW-1:0]   sel,
    output logic            valid,
    output logic            f
);
    arb_state_t      r_state, w_state_n;
    logic [SW-1:0]   r_sel, w_sel_n, r_ptr, w_ptr_n, w_pick_ptr, w_win;
    logic [INPS-1:0] r_gnt, w_gnt_n;
    logic [CW-1:0]   r_cnt, w_cnt_n;
    logic            w_any, w_rel;

    // During GRANT the search starts just past the holder, which is where ptr lands on release.
    assign w_pick_ptr = (r_state == ARB_GRANT) ? SW'(wrap_inc(int'(r_sel), INPS)) : r_ptr;

    rr_pick #(.INPS(INPS)) u_pick (
        .req(req),
        .ptr(w_pick_ptr),
        .winner(w_win),
        .any(w_any)
    );

    assign w_rel = !req[r_sel] || (MAX_HOLD != 0 && r_cnt == CW'(MAX_HOLD));

    always_comb begin
        w_state_n = r_state;
        w_sel_n = r_sel;
        w_gnt_n = r_gnt;
        w_ptr_n = r_ptr;
        w_cnt_n = r_cnt;
        if (r_state == ARB_IDLE || w_rel) begin
            if (r_state == ARB_GRANT) w_ptr_n = w_pick_ptr;
            if (w_any) begin
                w_state_n = ARB_GRANT;
                w_sel_n = w_win;
                w_gnt_n = INPS'(1) << w_win;
                w_cnt_n = CW'(1);
            end else begin
                w_state_n = ARB_IDLE;
                w_gnt_n = '0;
                w_cnt_n = '0;
            end
        end else if (MAX_HOLD != 0 && r_cnt != CW'(MAX_HOLD)) begin
            w_cnt_n = r_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ARB_IDLE;
            r_sel <= '0;
            r_gnt <= '0;
            r_ptr <= '0;
            r_cnt <= '0;
        end else begin
            r_state <= w_state_n;
            r_sel <= w_sel_n;
            r_gnt <= w_gnt_n;
            r_ptr <= w_ptr_n;
            r_cnt <= w_cnt_n;
        end
    end

    assign gnt = r_gnt;
    assign sel = r_sel;
    assign valid = (r_state == ARB_GRANT);
    assign f = valid ? w[r_sel] : 1'b0;
endmodule

// File: doc/mux_rr_arbiter.md
# mux_rr_arbiter

Round-robin arbiter that shares one N:1 1-bit mux output among N requesters. Each requester raises `req[i]` to own the mux. The block registers a one-hot grant and the matching binary select, then steers `w[sel]` to `f` while the grant is held. A hold limit stops any single requester from starving the others. It sits in front of the generic 1-bit mux datapath and replaces the free-running select with a sequenced, fair one.

## Interface
- `INPS`, default 5: number of requesters / mux inputs; must be ≥ 2.
- `MAX_HOLD`, default 4: maximum consecutive cycles one grant may be held; 0 means no limit.
- `SW` (localparam) = `$clog2(INPS)`.
- `CW` (localparam) = `$clog2(MAX_HOLD+1)`, minimum 1.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `req` input INPS: request vector; bit i is requester i.
- `w` input INPS: per-requester data bit, muxed to `f`.
- `gnt` output INPS: registered one-hot grant; all-zero when idle.
- `sel` output SW: registered binary index of the granted requester.
- `valid` output 1: registered; high while in GRANT.
- `f` output 1: combinational `w[sel]` when `valid` is high, else 0; never X.

## Operation
- State machine has two states:
  - IDLE: `valid`=0, `gnt`=0.
  - GRANT: `valid`=1, `gnt`=onehot(`sel`).
- Round-robin pointer `ptr` (SW bits) selects the highest-priority index. Priority descends `ptr`, `ptr`+1, … wrapping modulo INPS.
- Winner is the first index with `req` high, searching from `ptr`.
- IDLE → GRANT: at any edge where `req`≠0.
  - Load `sel`=winner and `gnt`=onehot(winner).
  - Set hold counter `cnt`=1.
- GRANT release occurs at an edge where either condition holds:
  - `req[sel]`=0, or
  - `MAX_HOLD`≠0, `cnt`==`MAX_HOLD` and `req[sel]`=1 (forced preempt).
- At a release edge:
  - Set `ptr`=(`sel`+1) mod INPS. The current holder becomes lowest priority.
  - If (`req` with bit `sel` masked when `req[sel]`=0) ≠ 0: regrant in the same edge (stay GRANT, load new winner, `cnt`=1). There is no idle gap.
  - Otherwise go to IDLE.
  - A forced preempt with the holder as sole requester regrants the same index with `cnt`=1.
- GRANT with no release: `cnt` increments. `cnt` saturates at `MAX_HOLD` and is unused when `MAX_HOLD`=0.
- Requests raised during GRANT by non-holders are ignored until the next release edge.
- Winner index arithmetic wraps modulo INPS, not modulo 2^SW. Indices ≥ INPS are never produced.

## Timing
- Reset (async, immediate, clock not required) sets: state=IDLE, `gnt`=0, `sel`=0, `valid`=0, `f`=0, `ptr`=0, `cnt`=0.
- Reset mid-GRANT drops `valid`/`gnt` at once. First arbitration after reset deassertion uses `ptr`=0.
- Request-to-grant latency is 1 cycle: `req` sampled at edge k gives `gnt`/`valid` visible after edge k.
- `f` has zero latency from `w`: a `w[sel]` change during GRANT appears in the same cycle. Changes on other `w` bits have no effect.
- Holder dropping `req[sel]` at edge k ends its grant at edge k. `gnt` of the next requester is visible after edge k.
- Maximum continuous ownership is `MAX_HOLD` cycles.
- Worst-case wait for a continuously requesting input is (INPS−1)·`MAX_HOLD` cycles plus 1.

## Structure
- Package `mux_arb_pkg` holds:
  - `typedef enum {ARB_IDLE, ARB_GRANT}` state type;
  - helper function `wrap_inc(idx, n)` for modulo increment.
- Sub-module `rr_pick`: purely combinational.
  - Inputs: `req`, `ptr`.
  - Outputs: `winner` (SW bits) and `any`.
  - Reused for both the initial grant and the release-edge regrant.
- The top level contains the FSM, `ptr`, `cnt`, the output registers and the `f` mux.

## Test plan
All scenarios use INPS=5, MAX_HOLD=4.
- Reset, then `req`=5'b00101 → after 1 edge: `gnt`=00001, `sel`=0, `valid`=1. Drop `req[0]` → next edge: `gnt`=00100, `sel`=2, with no idle cycle.
- `req`=11111 held constant → grants to 0,1,2,3,4,0 in turn, each exactly 4 cycles, `valid` never low.
- Only `req[3]` high for 12 cycles → `sel`=3 throughout. `cnt` restarts at each 4-cycle preempt. `gnt` stays 01000.
- In GRANT to 2, toggle `w[2]` 0→1→0 → `f` follows in the same cycle. Toggle `w[1]` → `f` unchanged. In IDLE, `w`=11111 → `f`=0.
- Grant to 4 released → `ptr`=0 (wrap). Next `req`=10001 → winner 0.
- Assert `rst` mid-GRANT between edges → `gnt`=0, `valid`=0, `f`=0 immediately. Release `rst` with `req`=00010 → `sel`=1 after 1 edge.
